led_band_fc_reader: RTL
=======================

Name: led_band_FC_reader

Overview:
Reads back the 48-bit function-control (FC) register of one TLC5957 LED driver so firmware and benches can confirm an FC write.
- Issues the TLC5957 READFC command: LAT held high for exactly 11 SCLK rising edges.
- Then shifts the 48 FC bits out of the driver's SOUT and presents them as a parallel word with a valid strobe and a compare flag.
- Sits beside led_band_FC_setter on the same SCLK/LAT/SIN/SOUT band interface; SCLK is free-running and generated elsewhere.

Parameters:
FC_WIDTH, 48, FC register width / number of bits shifted out.
READFC_EDGES, 11, SCLK rising edges counted while LAT is high for READFC.
SYNC_STAGES, 2, synchronizer depth applied to SCLK and SIN in the clk domain.

Ports:
clk  input  1  system clock; must be at least 4x SCLK frequency.
rst  input  1  asynchronous, active-low reset.
SCLK  input  1  free-running band shift clock, also seen by the driver.
start  input  1  one-clk pulse requesting a readback.
fc_expected  input  FC_WIDTH  reference value for comparison.
en  output  1  high while a readback is in progress (SCLK request).
LAT  output  1  driver latch/command line.
SOUT  output  1  data to driver SIN; held 0.
SIN  input  1  data from driver SOUT.
busy  output  1  high from accepted start until fc_valid.
fc_data  output  FC_WIDTH  captured FC word, MSB first on the wire.
fc_valid  output  1  one-clk pulse when fc_data is complete.
fc_match  output  1  (fc_data == fc_expected); updated with fc_valid.

Behaviour:
- Reset (rst=0, async): state IDLE; LAT, SOUT, en, busy, fc_valid, fc_match = 0; fc_data = 0; counters and synchronizers cleared. Reset mid-operation aborts immediately with LAT low; no fc_valid is issued.
- Synchronization: SCLK and SIN each pass through identical SYNC_STAGES-flop chains, so they stay aligned.
  - rise = sync(SCLK) 1 with previous 0.
  - fall = sync(SCLK) 0 with previous 1.
  - The bit captured on a rise is the delayed SIN sample from the clk cycle before SCLK went high.
- States:
  - IDLE: start=1 -> ARM; busy=en=1 in the next cycle. start while not IDLE is ignored.
  - ARM: on fall -> LAT_HI and LAT=1 in the same cycle; edge counter = 0.
  - LAT_HI: each rise increments the counter. On the first fall after the counter reaches READFC_EDGES, LAT=0 -> SHIFT with bit counter = 0. LAT changes only on falls.
  - SHIFT: each rise shifts the captured bit into fc_data LSB (left-shift), so the first bit becomes fc_data[FC_WIDTH-1]. After the FC_WIDTH-th rise -> DONE.
  - DONE: one clk; fc_valid=1, fc_match updated, busy=en=0 next cycle -> IDLE.
- Latency from start: one fall to arm, 11 rises with LAT high, one fall, then 48 rises. Roughly 61 SCLK periods plus 2-3 clk of sync delay.
- If SCLK stops, the FSM waits indefinitely; there is no timeout.
- fc_data holds its last value while IDLE and during the next capture, except that bits shift during SHIFT.
- Simultaneous start and rst: reset wins.
- Counter widths: $clog2(READFC_EDGES+1) and $clog2(FC_WIDTH+1). A counter never wraps because its terminal count forces the state transition.

Decomposition:
- Shared package led_band_pkg:
  - FC_WIDTH.
  - TLC5957 command edge counts: WRTGS=1, LATGS=3, WRTFC=5, LINERESET=7, READFC=11, TMGRST=13, FCWRTEN=15.
  - FC reader state enum.
- One sub-module, sclk_edge_sync: SCLK/SIN synchronizers plus rise/fall strobes and the aligned SIN sample. It is reusable by led_band_FC_setter.

Test Plan:
- Write 48'hec020100804e to the tlc5957 model via led_band_FC_setter (FCWRTEN then WRTFC), then pulse start with fc_expected equal to that value -> LAT high for exactly 11 SCLK rises, fc_valid pulses once, fc_data=48'hec020100804e, fc_match=1.
- Same readback with fc_expected=48'h000000000000 -> fc_data=48'hec020100804e, fc_match=0.
- Pulse start again mid-SHIFT -> ignored; exactly one fc_valid; LAT rises exactly once.
- Assert rst during SHIFT -> LAT, busy, en go 0 immediately; no fc_valid; a subsequent start completes with the correct value.
- Two back-to-back readbacks (start in the cycle after fc_valid) -> both return 48'hec020100804e; SOUT stays 0 throughout.
- Hold SCLK static after start -> busy and en stay 1, LAT stays 0 in ARM; resume SCLK -> normal completion.

Source files
------------

// File: rtl/led_band_pkg.sv
// Shared definitions for the TLC5957 LED band interface blocks:
// FC register width, command edge counts (SCLK rising edges with LAT high)
// and the FC reader state encoding.
package led_band_pkg;

  localparam int FC_WIDTH = 48;

  // TLC5957 commands are selected by the number of SCLK rising edges seen
  // while LAT is high.
  localparam int CMD_WRTGS_EDGES     = 1;
  localparam int CMD_LATGS_EDGES     = 3;
  localparam int CMD_WRTFC_EDGES     = 5;
  localparam int CMD_LINERESET_EDGES = 7;
  localparam int CMD_READFC_EDGES    = 11;
  localparam int CMD_TMGRST_EDGES    = 13;
  localparam int CMD_FCWRTEN_EDGES   = 15;

  typedef enum logic [2:0] {
    FCR_IDLE   = 3'd0,
    FCR_ARM    = 3'd1,
    FCR_LAT_HI = 3'd2,
    FCR_SHIFT  = 3'd3,
    FCR_DONE   = 3'd4
  } fc_rd_state_e;

endpackage

// File: rtl/sclk_edge_sync.sv
// Brings the band SCLK and the driver's serial output into the clk domain
// through identical synchronizer chains, so both stay cycle-aligned, and
// derives SCLK rise/fall strobes plus the data bit to capture on a rise.
module sclk_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic SCLK,
  input  logic SIN,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic sin_bit
);

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] sin_sync_r;
  logic                   sclk_prev_r;
  logic                   sin_prev_r;
  logic                   sclk_s;

  assign sclk_s = sclk_sync_r[SYNC_STAGES-1];

  // Synchronizer chains plus one extra stage of history for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      sin_sync_r  <= {SYNC_STAGES{1'b0}};
      sclk_prev_r <= 1'b0;
      sin_prev_r  <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], SCLK};
      sin_sync_r  <= {sin_sync_r[SYNC_STAGES-2:0], SIN};
      sclk_prev_r <= sclk_s;
      sin_prev_r  <= sin_sync_r[SYNC_STAGES-1];
    end
  end

  // On a rise, sin_prev_r is the data sampled alongside the last SCLK-low
  // sample, i.e. the bit that was stable just before SCLK went high.
  assign sclk_rise = sclk_s & ~sclk_prev_r;
  assign sclk_fall = ~sclk_s & sclk_prev_r;
  assign sin_bit   = sin_prev_r;

endmodule

// File: rtl/led_band_fc_reader.sv
// Reads back the TLC5957 function-control register: issues READFC (LAT high
// for READFC_EDGES SCLK rises), then shifts FC_WIDTH bits in from the
// driver, presenting the word with a valid strobe and a compare flag.
module led_band_fc_reader #(
  parameter int FC_WIDTH     = led_band_pkg::FC_WIDTH,
  parameter int READFC_EDGES = led_band_pkg::CMD_READFC_EDGES,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                SCLK,
  input  logic                start,
  input  logic [FC_WIDTH-1:0] fc_expected,
  output logic                en,
  output logic                LAT,
  output logic                SOUT,
  input  logic                SIN,
  output logic                busy,
  output logic [FC_WIDTH-1:0] fc_data,
  output logic                fc_valid,
  output logic                fc_match
);

  import led_band_pkg::*;

  localparam int EDGE_CW = $clog2(READFC_EDGES + 1);
  localparam int BIT_CW  = $clog2(FC_WIDTH + 1);
  localparam logic [EDGE_CW-1:0] EDGE_LAST = EDGE_CW'(READFC_EDGES);
  localparam logic [BIT_CW-1:0]  BIT_LAST  = BIT_CW'(FC_WIDTH - 1);

  fc_rd_state_e        state_r, state_s;
  logic [EDGE_CW-1:0]  edge_cnt_r, edge_cnt_s;
  logic [BIT_CW-1:0]   bit_cnt_r, bit_cnt_s;
  logic [FC_WIDTH-1:0] fc_data_r, fc_data_s;
  logic                lat_r, lat_s;
  logic                busy_r, busy_s;
  logic                fc_valid_r, fc_valid_s;
  logic                fc_match_r, fc_match_s;

  logic                sclk_rise_s;
  logic                sclk_fall_s;
  logic                sin_bit_s;

  sclk_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .SCLK     (SCLK),
    .SIN      (SIN),
    .sclk_rise(sclk_rise_s),
    .sclk_fall(sclk_fall_s),
    .sin_bit  (sin_bit_s)
  );

  // State and output registers; reset aborts any readback with LAT low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= FCR_IDLE;
      edge_cnt_r <= {EDGE_CW{1'b0}};
      bit_cnt_r  <= {BIT_CW{1'b0}};
      fc_data_r  <= {FC_WIDTH{1'b0}};
      lat_r      <= 1'b0;
      busy_r     <= 1'b0;
      fc_valid_r <= 1'b0;
      fc_match_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      edge_cnt_r <= edge_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      fc_data_r  <= fc_data_s;
      lat_r      <= lat_s;
      busy_r     <= busy_s;
      fc_valid_r <= fc_valid_s;
      fc_match_r <= fc_match_s;
    end
  end

  // Next-state logic; LAT only moves on SCLK falls so the driver sees it
  // stable around every rising edge.
  always_comb begin
    state_s    = state_r;
    edge_cnt_s = edge_cnt_r;
    bit_cnt_s  = bit_cnt_r;
    fc_data_s  = fc_data_r;
    lat_s      = lat_r;
    busy_s     = busy_r;
    fc_valid_s = 1'b0;
    fc_match_s = fc_match_r;

    case (state_r)
      FCR_IDLE: begin
        if (start) begin
          state_s    = FCR_ARM;
          busy_s     = 1'b1;
          edge_cnt_s = {EDGE_CW{1'b0}};
          bit_cnt_s  = {BIT_CW{1'b0}};
        end else begin
          busy_s = 1'b0;
          lat_s  = 1'b0;
        end
      end

      FCR_ARM: begin
        if (sclk_fall_s) begin
          state_s    = FCR_LAT_HI;
          lat_s      = 1'b1;
          edge_cnt_s = {EDGE_CW{1'b0}};
        end else begin
          state_s = FCR_ARM;
        end
      end

      FCR_LAT_HI: begin
        if (sclk_rise_s && (edge_cnt_r != EDGE_LAST)) begin
          edge_cnt_s = edge_cnt_r + EDGE_CW'(1);
        end else if (sclk_fall_s && (edge_cnt_r == EDGE_LAST)) begin
          state_s   = FCR_SHIFT;
          lat_s     = 1'b0;
          bit_cnt_s = {BIT_CW{1'b0}};
        end else begin
          state_s = FCR_LAT_HI;
        end
      end

      FCR_SHIFT: begin
        if (sclk_rise_s) begin
          fc_data_s = {fc_data_r[FC_WIDTH-2:0], sin_bit_s};
          bit_cnt_s = bit_cnt_r + BIT_CW'(1);
          if (bit_cnt_r == BIT_LAST) begin
            state_s    = FCR_DONE;
            fc_valid_s = 1'b1;
            fc_match_s = (fc_data_s == fc_expected);
          end else begin
            state_s = FCR_SHIFT;
          end
        end else begin
          state_s = FCR_SHIFT;
        end
      end

      FCR_DONE: begin
        state_s = FCR_IDLE;
        busy_s  = 1'b0;
      end

      default: begin
        state_s = FCR_IDLE;
        lat_s   = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  assign LAT      = lat_r;
  assign busy     = busy_r;
  assign en       = busy_r;
  assign SOUT     = 1'b0;
  assign fc_data  = fc_data_r;
  assign fc_valid = fc_valid_r;
  assign fc_match = fc_match_r;

endmodule
